uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of characters feeding a serial framer (start, data LSB first, stop).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    state_t               state_q,    state_d;
    logic                 tx_q,       tx_d;
    logic [LVL_W-1:0]     level_q,    level_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [BAUD_W-1:0]    baud_q,     baud_d;
    logic [BIT_W-1:0]     bit_q,      bit_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q,     busy_d;
    logic                 wr_ready_q, wr_ready_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q,   parity_d;
`endif

    logic                 push_s;
    logic                 pop_s;
    logic                 start_frame_s;
    logic [DATA_BITS-1:0] head_s;

    assign push_s = wr_valid & wr_ready_q;
    assign head_s = mem_q[rd_ptr_q];

    // Framer: sequences start, data, optional parity and stop bits, and decides when to pop the FIFO.
    always_comb begin
        state_d       = state_q;
        tx_d          = tx_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        start_frame_s = 1'b0;
        pop_s         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d      = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != LVL_ZERO) begin
                    start_frame_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = BIT_ZERO;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = BAUD_ZERO;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    if (level_q != LVL_ZERO) begin
                        start_frame_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = BAUD_ZERO;
                bit_d   = BIT_ZERO;
            end
        endcase

        // Back-to-back frames reuse this path so the next start bit follows the stop bit directly.
        if (start_frame_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            state_d = S_START;
            tx_d    = 1'b0;
            baud_d  = BAUD_ZERO;
            bit_d   = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(head_s);
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO bookkeeping plus next values of the registered status outputs.
    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        overflow_d = overflow_q | (wr_valid & ~wr_ready_q);
        busy_d     = (state_d != S_IDLE) || (level_d != LVL_ZERO);
        wr_ready_d = (level_d != LVL_FULL);
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            level_q    <= LVL_ZERO;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            baud_q     <= BAUD_ZERO;
            bit_q      <= BIT_ZERO;
            shift_q    <= {DATA_BITS{1'b0}};
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Character storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model of the FIFO and the serial line.
module tb_uart_tx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int CPB   = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = CPB * (DB + 2 + PAR_BITS);

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_valid;
    logic [DB-1:0]    wr_data;
    logic             wr_ready;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    int mq[$];
    bit line[$];
    bit m_ovf = 1'b0;

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .tx(tx), .busy(busy), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Appends the per-cycle line values of one complete frame for character c.
    task automatic expand(input int c);
        bit p;
        p = 1'b0;
        for (int k = 0; k < CPB; k++) line.push_back(1'b0);
        for (int b = 0; b < DB; b++) begin
            p = p ^ bit'((c >> b) & 1);
            for (int k = 0; k < CPB; k++) line.push_back(bit'((c >> b) & 1));
        end
        for (int k = 0; k < CPB * PAR_BITS; k++) line.push_back(p);
        for (int k = 0; k < CPB; k++) line.push_back(1'b1);
    endtask

    // Reference behaviour at one rising edge, from pre-edge occupancy and line state.
    task automatic model_edge();
        bit ready_pre;
        bit can_pop;
        int c;
        if (!reset) begin
            mq.delete();
            line.delete();
            m_ovf = 1'b0;
            return;
        end
        ready_pre = (mq.size() != DEPTH);
        if (line.size() != 0) void'(line.pop_front());
        can_pop = (line.size() == 0) && (mq.size() != 0);
        if (wr_valid && !ready_pre) m_ovf = 1'b1;
        if (can_pop) begin
            c = mq.pop_front();
            expand(c);
        end
        if (wr_valid && ready_pre) mq.push_back(int'(wr_data));
    endtask

    function automatic logic [LVL_W+3:0] exp_pack();
        bit etx;
        etx = (line.size() != 0) ? line[0] : 1'b1;
        return {etx, (line.size() != 0) || (mq.size() != 0), mq.size() != DEPTH, m_ovf, LVL_W'(mq.size())};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b1; wr_data = 8'hFF;
        tick(); tick();
        n_tests++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_tests++; if (level !== 5'd0)    begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset = 1'b1; wr_valid = 1'b0;
        tick();
        n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
            begin n_fail++; $display("FAIL reset_idle: got %h expected %h", {tx, busy, wr_ready, overflow, level}, exp_pack()); end
    endtask

    task automatic test_single();
        wr_valid = 1'b1; wr_data = 8'h55;
        tick();
        wr_valid = 1'b0;
        n_tests++; if (level !== 5'd1 || tx !== 1'b1)
            begin n_fail++; $display("FAIL single_accept: got level %0d tx %b expected level 1 tx 1", level, tx); end
        tick();
        for (int i = 0; i < FRAME + 3; i++) begin
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL single_cyc%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
            if (i == 0 || i == 2 * CPB) begin
                n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL single_low%0d: got %b expected 0", i, tx); end
            end
            if (i == CPB || i == FRAME - CPB || i == FRAME - 1) begin
                n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_high%0d: got %b expected 1", i, tx); end
            end
            if (i == FRAME) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got busy %b expected 0", busy); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_data = 8'hA3;
        tick();
        wr_data = 8'h0F;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL b2b_cyc%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
            if (i == 0 || i == FRAME || i == CPB * 3) begin
                n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_low%0d: got %b expected 0", i, tx); end
            end
            if (i == FRAME - 1 || i == CPB || i == FRAME + CPB) begin
                n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_high%0d: got %b expected 1", i, tx); end
            end
            if (i == 2 * FRAME) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got busy %b expected 0", busy); end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        reset = 1'b0; tick(); reset = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h11; tick();
        wr_valid = 1'b0; tick(); tick();
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1; wr_data = DB'($urandom);
            tick();
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL ovf_wr%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
        end
        wr_valid = 1'b0;
        n_tests++; if (level !== 5'd16 || wr_ready !== 1'b0 || overflow !== 1'b1)
            begin n_fail++; $display("FAIL ovf_full: got level %0d ready %b ovf %b expected 16 0 1", level, wr_ready, overflow); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_tests++; if (overflow !== 1'b1 || {tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL ovf_sticky%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
        end
    endtask

    task automatic test_full_pop();
        int guard;
        reset = 1'b0; tick(); reset = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h3C; tick();
        wr_valid = 1'b0; tick(); tick();
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = DB'($urandom); tick();
        end
        wr_valid = 1'b0;
        n_tests++; if (level !== 5'd16 || overflow !== 1'b0)
            begin n_fail++; $display("FAIL fullpop_fill: got level %0d ovf %b expected 16 0", level, overflow); end
        guard = 0;
        while (line.size() != 1 && guard < 2 * FRAME) begin tick(); guard++; end
        n_tests++; if (guard >= 2 * FRAME) begin n_fail++; $display("FAIL fullpop_wait: got timeout expected pop edge"); end
        wr_valid = 1'b1; wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        n_tests++; if (level !== 5'd15 || overflow !== 1'b1 || tx !== 1'b0)
            begin n_fail++; $display("FAIL fullpop_edge: got level %0d ovf %b tx %b expected 15 1 0", level, overflow, tx); end
        guard = 0;
        while ((busy !== 1'b0 || line.size() != 0) && guard < (DEPTH + 1) * FRAME) begin
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL fullpop_drain%0d: got %h expected %h", guard, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
            tick(); guard++;
        end
        n_tests++; if (guard >= (DEPTH + 1) * FRAME) begin n_fail++; $display("FAIL fullpop_drain: got timeout expected idle"); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_data = DB'($urandom); tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) tick();
        n_tests++; if (level !== 5'd5 || busy !== 1'b1)
            begin n_fail++; $display("FAIL midrst_pre: got level %0d busy %b expected 5 1", level, busy); end
        reset = 1'b0; wr_valid = 1'b1; wr_data = 8'h99;
        tick();
        n_tests++; if (tx !== 1'b1 || level !== 5'd0 || busy !== 1'b0 || wr_ready !== 1'b1 || overflow !== 1'b0)
            begin n_fail++; $display("FAIL midrst_edge: got tx %b level %0d busy %b ready %b ovf %b expected 1 0 0 1 0",
                                     tx, level, busy, wr_ready, overflow); end
        reset = 1'b1; wr_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_tests++; if (tx !== 1'b1 || {tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL midrst_after%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
        end
    endtask

    task automatic test_random();
        int guard;
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 99) < ((i % 1000) < 500 ? 2 : 60));
            wr_data  = DB'($urandom);
            tick();
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL random%0d: got %h expected %h", i, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
        end
        wr_valid = 1'b0;
        guard = 0;
        while ((line.size() != 0 || mq.size() != 0) && guard < (DEPTH + 1) * FRAME) begin
            tick(); guard++;
            n_tests++; if ({tx, busy, wr_ready, overflow, level} !== exp_pack())
                begin n_fail++; $display("FAIL rnd_drain%0d: got %h expected %h", guard, {tx, busy, wr_ready, overflow, level}, exp_pack()); end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle: got busy %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b0; wr_valid = 1'b0; wr_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
